// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter: grant states,
// default bus widths, reset level and counter sizing.
package mem_bus_arbiter_pkg;

   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned DATA_WIDTH = 32;

   localparam logic RST_ACTIVE = 1'b1;

   localparam logic [3:0] BYTE_SEL_ALL = 4'b1111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_EX = 2'd1,
      GNT_IF = 2'd2
   } arb_state_t;

   // Width needed to hold 0..max; a disabled (0) limit still gets one bit.
   function automatic int unsigned cnt_width(input int unsigned max);
      return (max < 2) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_counter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX = 4,
   parameter int unsigned W   = cnt_width(MAX)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] LIM = W'(MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ACTIVE) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != LIM)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master memory port arbiter: fixed EX priority with an IF starvation
// guard, a bus_ack watchdog and a pipeline hold for outstanding loads/stores.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_WIDTH,
   parameter int unsigned DATA_W     = DATA_WIDTH,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_req,
   input  logic              ex_we,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic [3:0]        ex_byte_sel,
   output logic [DATA_W-1:0] ex_rdata,
   output logic              ex_ack,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [3:0]        bus_byte_sel,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack,
   output logic              hold_o,
   output logic              bus_err_o
);

   localparam int unsigned   SW          = cnt_width(STARVE_MAX);
   localparam int unsigned   WW          = cnt_width(TIMEOUT);
   localparam logic [SW-1:0] STARVE_LIM  = SW'(STARVE_MAX);
   localparam logic [WW-1:0] TIMEOUT_LIM = WW'(TIMEOUT);
   localparam logic          STARVE_EN   = (STARVE_MAX != 0);
   localparam logic          TIMEOUT_EN  = (TIMEOUT != 0);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic [SW-1:0] starve_cnt;
   logic [WW-1:0] wait_cnt;
   logic          granted;
   logic          timeout;
   logic          done;
   logic          decide;
   logic          starve_hit;
   logic          grant_ex;
   logic          grant_if;

   assign granted    = (state != IDLE);
   assign timeout    = TIMEOUT_EN && granted && !bus_ack && (wait_cnt == TIMEOUT_LIM);
   assign done       = granted && (bus_ack || timeout);
   // Arbitration happens from IDLE and on the completing cycle, so a
   // re-grant lands on the very next edge without an idle bubble.
   assign decide     = !granted || done;
   assign starve_hit = if_req && STARVE_EN && (starve_cnt == STARVE_LIM);
   assign grant_ex   = decide && ex_req && !starve_hit;
   assign grant_if   = decide && !grant_ex && if_req;

   arb_counter #(
      .MAX (STARVE_MAX),
      .W   (SW)
   ) u_starve_cnt (
      .clk (clk),
      .rst (rst),
      .clr (!if_req || grant_if),
      .inc (grant_ex && if_req),
      .cnt (starve_cnt)
   );

   arb_counter #(
      .MAX (TIMEOUT),
      .W   (WW)
   ) u_wait_cnt (
      .clk (clk),
      .rst (rst),
      .clr (!granted || done),
      .inc (granted && !bus_ack),
      .cnt (wait_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ACTIVE) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (decide) begin
         if (grant_ex) begin
            state_nxt = GNT_EX;
         end else if (grant_if) begin
            state_nxt = GNT_IF;
         end else begin
            state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ACTIVE) begin
         bus_we       <= 1'b0;
         bus_addr     <= '0;
         bus_wdata    <= '0;
         bus_byte_sel <= '0;
      end else if (grant_ex) begin
         bus_we       <= ex_we;
         bus_addr     <= ex_addr;
         bus_wdata    <= ex_wdata;
         bus_byte_sel <= ex_byte_sel;
      end else if (grant_if) begin
         bus_we       <= 1'b0;
         bus_addr     <= if_addr;
         bus_byte_sel <= BYTE_SEL_ALL;
      end
   end

   // Aborted transfers complete with zero data so the master never hangs.
   always_comb begin
      bus_req   = granted;
      ex_ack    = (state == GNT_EX) && done;
      if_ack    = (state == GNT_IF) && done;
      bus_err_o = timeout;
      ex_rdata  = (ex_ack && !timeout) ? bus_rdata : '0;
      if_rdata  = (if_ack && !timeout) ? bus_rdata : '0;
      hold_o    = ex_req && !ex_ack;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a transaction-level model predicts
// grant order and responses; a separate monitor checks DUT outputs.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   localparam int unsigned SMAX = 4;
   localparam int unsigned TMO  = 15;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [3:0]  bsel;
      int unsigned lat;
   } txn_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   typedef struct {
      logic is_if;
      txn_t t;
   } grant_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_req, ex_we, ex_ack, if_req, if_ack;
   logic [31:0] ex_addr, ex_wdata, ex_rdata, if_addr, if_rdata;
   logic [3:0]  ex_byte_sel, bus_byte_sel;
   logic        bus_req, bus_we, bus_ack, hold_o, bus_err_o;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;

   txn_t   ex_q[$], if_q[$];
   resp_t  exp_ex[$], exp_if[$];
   grant_t gq[$];

   int unsigned errors = 0;
   int unsigned checks = 0;

   bit          in_rst = 1'b1;
   bit          m_busy = 1'b0, m_busy_cur = 1'b0, m_is_if = 1'b0;
   txn_t        m_cur;
   int unsigned m_wait = 0, m_starve = 0, late_cnt = 0;
   bit          d_ack, d_tmo, d_done, g_ex, g_if;
   bit          prev_req = 1'b0, prev_ack = 1'b0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .STARVE_MAX (SMAX),
      .TIMEOUT    (TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ex_req       (ex_req),
      .ex_we        (ex_we),
      .ex_addr      (ex_addr),
      .ex_wdata     (ex_wdata),
      .ex_byte_sel  (ex_byte_sel),
      .ex_rdata     (ex_rdata),
      .ex_ack       (ex_ack),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_rdata     (if_rdata),
      .if_ack       (if_ack),
      .bus_req      (bus_req),
      .bus_we       (bus_we),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_byte_sel (bus_byte_sel),
      .bus_rdata    (bus_rdata),
      .bus_ack      (bus_ack),
      .hold_o       (hold_o),
      .bus_err_o    (bus_err_o)
   );

   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h00100093;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event not expected or did not occur", name);
   endtask

   task automatic issue_ex(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input logic [3:0] bs, input int unsigned lat);
      txn_t  t;
      resp_t r;
      t = '{addr: a, wdata: wd, we: we, bsel: bs, lat: lat};
      r = '{rdata: (lat > TMO) ? 32'h0 : rd_fn(a), err: (lat > TMO)};
      ex_q.push_back(t);
      exp_ex.push_back(r);
   endtask

   task automatic issue_if(input logic [31:0] a, input int unsigned lat);
      txn_t  t;
      resp_t r;
      t = '{addr: a, wdata: 32'h0, we: 1'b0, bsel: 4'b1111, lat: lat};
      r = '{rdata: (lat > TMO) ? 32'h0 : rd_fn(a), err: (lat > TMO)};
      if_q.push_back(t);
      exp_if.push_back(r);
   endtask

   task automatic wait_idle(input string name);
      int unsigned n = 0;
      while ((ex_q.size() != 0 || if_q.size() != 0 || m_busy || late_cnt != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) fail({name, "_drain_timeout"});
      @(negedge clk);
      #3;
      check({name, "_resp_left"}, 32'(exp_ex.size() + exp_if.size()), 32'd0);
      check({name, "_grant_left"}, 32'(gq.size()), 32'd0);
   endtask

   // Slave responder, request drivers and transaction-level arbitration model.
   always begin
      @(negedge clk);
      m_busy_cur = m_busy;
      if (in_rst) begin
         bus_ack = 1'b0;
      end else begin
         if (m_busy) d_ack = (m_wait == m_cur.lat);
         else        d_ack = (late_cnt == 1) || ($urandom_range(0, 3) == 0);
         if (late_cnt != 0) late_cnt--;
         bus_ack   = d_ack;
         bus_rdata = (m_busy && d_ack) ? rd_fn(m_cur.addr) : $urandom;
         d_tmo  = m_busy && !d_ack && (m_wait == TMO);
         d_done = m_busy && (d_ack || d_tmo);
         if (d_tmo && m_cur.lat < TMO + 10) late_cnt = m_cur.lat - TMO;
         #2;
         if (d_done) begin
            if (m_is_if) void'(if_q.pop_front());
            else         void'(ex_q.pop_front());
            m_busy = 1'b0;
         end else if (m_busy) begin
            m_wait++;
         end
         ex_req = (ex_q.size() != 0);
         if (ex_req) begin
            ex_addr     = ex_q[0].addr;
            ex_we       = ex_q[0].we;
            ex_wdata    = ex_q[0].wdata;
            ex_byte_sel = ex_q[0].bsel;
         end
         if_req = (if_q.size() != 0);
         if (if_req) if_addr = if_q[0].addr;
         g_ex = 1'b0;
         g_if = 1'b0;
         if (!m_busy) begin
            if (ex_req && !(if_req && SMAX != 0 && m_starve == SMAX)) g_ex = 1'b1;
            else if (if_req)                                         g_if = 1'b1;
         end
         if (g_ex || g_if) begin
            m_busy  = 1'b1;
            m_is_if = g_if;
            m_cur   = g_if ? if_q[0] : ex_q[0];
            m_wait  = 0;
            gq.push_back('{is_if: g_if, t: m_cur});
         end
         if (!if_req || g_if)            m_starve = 0;
         else if (g_ex && m_starve < SMAX) m_starve++;
      end
   end

   // Monitor: compares DUT outputs against the model's predictions.
   always begin
      grant_t g;
      resp_t  r;
      @(negedge clk);
      #1;
      if (!in_rst) begin
         check("bus_req", 32'(bus_req), 32'(m_busy_cur));
         check("hold_o", 32'(hold_o), 32'(ex_req && !ex_ack));
         if (ex_ack && if_ack) fail("dual_ack");
         if (bus_req && (!prev_req || prev_ack)) begin
            if (gq.size() == 0) begin
               fail("grant_unexpected");
            end else begin
               g = gq.pop_front();
               check("bus_addr", bus_addr, g.t.addr);
               check("bus_we", 32'(bus_we), 32'(g.is_if ? 1'b0 : g.t.we));
               check("bus_byte_sel", 32'(bus_byte_sel), 32'(g.is_if ? 4'b1111 : g.t.bsel));
               if (!g.is_if) check("bus_wdata", bus_wdata, g.t.wdata);
            end
         end
         if (ex_ack) begin
            if (exp_ex.size() == 0) begin
               fail("ex_ack_unexpected");
            end else begin
               r = exp_ex.pop_front();
               check("ex_rdata", ex_rdata, r.rdata);
               check("ex_err", 32'(bus_err_o), 32'(r.err));
            end
         end
         if (if_ack) begin
            if (exp_if.size() == 0) begin
               fail("if_ack_unexpected");
            end else begin
               r = exp_if.pop_front();
               check("if_rdata", if_rdata, r.rdata);
               check("if_err", 32'(bus_err_o), 32'(r.err));
            end
         end
         if (!ex_ack && !if_ack) check("bus_err_idle", 32'(bus_err_o), 32'd0);
      end
      prev_req = bus_req;
      prev_ack = ex_ack || if_ack;
   end

   initial begin
      int unsigned n;
      rst = RST_ACTIVE;
      {ex_req, ex_we, if_req, bus_ack} = '0;
      ex_addr = '0; ex_wdata = '0; ex_byte_sel = '0; if_addr = '0; bus_rdata = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_bus_req", 32'(bus_req), 32'd0);
      check("rst_bus_we", 32'(bus_we), 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_bus_wdata", bus_wdata, 32'd0);
      check("rst_bus_byte_sel", 32'(bus_byte_sel), 32'd0);
      check("rst_acks", 32'({ex_ack, if_ack, bus_err_o}), 32'd0);
      check("rst_rdata", ex_rdata | if_rdata, 32'd0);
      #2;
      rst = 1'b0;
      in_rst = 1'b0;

      issue_if(32'h0, 0);
      wait_idle("t1_if_only");

      issue_ex(32'h4, 1'b0, 32'h0, 4'b0011, 2);
      issue_if(32'h8, 0);
      wait_idle("t2_simultaneous");

      for (int i = 0; i < 6; i++)
         issue_ex(32'h1000 + 32'(i) * 4, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 2));
      issue_if(32'h2000, 1);
      wait_idle("t3_starve");

      issue_ex(32'h30, 1'b1, 32'hDEADBEEF, 4'b0001, 1);
      wait_idle("t4_store");

      issue_ex(32'h100, 1'b0, 32'h0, 4'b1111, TMO + 3);
      wait_idle("t5_timeout");

      issue_ex(32'h200, 1'b0, 32'h0, 4'b1111, 1000);
      n = 0;
      while (!(m_busy && !m_is_if) && n < 20) begin
         @(negedge clk);
         #3;
         n++;
      end
      if (n >= 20) fail("t6_grant_wait");
      repeat (3) @(negedge clk);
      @(posedge clk);
      #3;
      in_rst = 1'b1;
      rst = RST_ACTIVE;
      ex_req = 1'b0;
      if_req = 1'b0;
      #1;
      check("t6_bus_req", 32'(bus_req), 32'd0);
      check("t6_acks", 32'({ex_ack, if_ack, bus_err_o}), 32'd0);
      check("t6_hold_o", 32'(hold_o), 32'd0);
      ex_q.delete(); exp_ex.delete(); gq.delete();
      m_busy = 1'b0; m_starve = 0; m_wait = 0; late_cnt = 0;
      repeat (2) @(negedge clk);
      #3;
      rst = 1'b0;
      in_rst = 1'b0;
      issue_if(32'h40, 1);
      wait_idle("t6_after_reset");

      for (int b = 0; b < 5; b++) begin
         for (int i = 0; i < $urandom_range(0, 8); i++)
            issue_ex($urandom & 32'hFFFC, 1'($urandom), $urandom, 4'($urandom),
                     ($urandom_range(0, 9) == 0) ? TMO + 2 : $urandom_range(0, 3));
         for (int i = 0; i < $urandom_range(1, 8); i++)
            issue_if($urandom & 32'hFFFC,
                     ($urandom_range(0, 9) == 0) ? TMO + 2 : $urandom_range(0, 3));
         wait_idle("rand_burst");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
